// File: rtl/stim_gen_hs.sv
// stim_gen_hs: multi-operand pseudo-random stimulus source with valid/ready
// handshake, result counting, drain period and timeout watchdog.
//
// Ports:
//   CLK      in   clock
//   RST_n    in   synchronous active-low reset
//   EN       in   start/continue issuing transactions
//   D        out  NUM_OPERANDS operands, channel k at D[k*WIDTH +: WIDTH]
//   VOUT     out  operands valid
//   RDY      in   downstream ready
//   VIN      in   one pulse per returned result
//   END_SIM  out  sticky end-of-simulation flag
//   ERR      out  sticky timeout / over-receive flag
//   TX_CNT   out  accepted transactions
//   RX_CNT   out  results received
module stim_gen_hs #(
  parameter int unsigned WIDTH        = 32,
  parameter int unsigned NUM_OPERANDS = 3,
  parameter int unsigned N_VECTORS    = 1000,
  parameter logic [31:0] SEED         = 32'h1,
  parameter bit          BUBBLE_EN    = 1'b0,
  parameter int unsigned DRAIN_CYCLES = 8,
  parameter int unsigned TIMEOUT      = 1024
) (
  input  logic                          CLK,
  input  logic                          RST_n,
  input  logic                          EN,
  output logic [NUM_OPERANDS*WIDTH-1:0] D,
  output logic                          VOUT,
  input  logic                          RDY,
  input  logic                          VIN,
  output logic                          END_SIM,
  output logic                          ERR,
  output logic [20:0]                   TX_CNT,
  output logic [20:0]                   RX_CNT
);

  localparam int unsigned CNT_W   = 21;
  localparam int unsigned LFSR_W  = 32;
  localparam int unsigned D_W     = NUM_OPERANDS * WIDTH;
  localparam int unsigned DRAIN_W = 8;
  localparam int unsigned TO_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  localparam logic [31:0] LFSR_MASK = 32'h8020_0003;
  localparam logic [31:0] GOLDEN    = 32'h9E37_79B9;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_RUN   = 3'd1;
  localparam logic [2:0] S_WAIT  = 3'd2;
  localparam logic [2:0] S_DRAIN = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  // Right-shifting Galois step for x^32+x^22+x^2+x+1
  function automatic logic [31:0] lfsr_step(input logic [31:0] s);
    return (s >> 1) ^ (s[0] ? LFSR_MASK : 32'h0);
  endfunction

  // An all-zero LFSR would lock up, so zero seeds become 1
  function automatic logic [31:0] nonzero(input logic [31:0] s);
    return (s == 32'h0) ? 32'h1 : s;
  endfunction

  function automatic logic [31:0] chan_seed(input int unsigned k);
    return nonzero(SEED ^ (32'(k) * GOLDEN));
  endfunction

  logic [2:0]         state_q, state_d;
  logic [LFSR_W-1:0]  lfsr_q [NUM_OPERANDS];
  logic [LFSR_W-1:0]  lfsr_d [NUM_OPERANDS];
  logic [LFSR_W-1:0]  bub_q, bub_d;
  logic [D_W-1:0]     d_q, d_d, d_next_c;
  logic               vout_q, vout_d;
  logic               end_q, end_d;
  logic               err_q, err_d;
  logic [CNT_W-1:0]   tx_q, tx_d;
  logic [CNT_W-1:0]   rx_q, rx_d;
  logic [DRAIN_W-1:0] drain_q, drain_d;
  logic [TO_W-1:0]    to_q, to_d;

  logic xfer_c, last_c, slot_free_c, skip_c;

  assign xfer_c      = vout_q & RDY;
  assign last_c      = xfer_c && (tx_q == CNT_W'(N_VECTORS - 1));
  // A new operand set may be staged when nothing is pending or the pending one leaves now
  assign slot_free_c = !vout_q || xfer_c;
  assign skip_c      = BUBBLE_EN && (bub_q[1:0] == 2'b00);

  // Channel LFSRs advance only on a transfer; next operand word taken from the advanced state
  always_comb begin
    d_next_c = '0;
    for (int unsigned k = 0; k < NUM_OPERANDS; k++) begin
      lfsr_d[k] = xfer_c ? lfsr_step(lfsr_q[k]) : lfsr_q[k];
      d_next_c[k*WIDTH +: WIDTH] = lfsr_d[k][WIDTH-1:0];
    end
  end

  // Next-state and output logic
  always_comb begin
    state_d = state_q;
    vout_d  = vout_q;
    d_d     = d_q;
    tx_d    = tx_q + CNT_W'(xfer_c);
    rx_d    = rx_q;
    err_d   = err_q;
    drain_d = drain_q;
    to_d    = to_q;
    bub_d   = bub_q;

    unique case (state_q)
      S_IDLE: begin
        vout_d = 1'b0;
        if (EN) state_d = S_RUN;
      end
      S_RUN: begin
        bub_d = lfsr_step(bub_q);
        if (last_c) begin
          vout_d  = 1'b0;
          state_d = S_WAIT;
        end else if (slot_free_c) begin
          if (EN && !skip_c) begin
            vout_d = 1'b1;
            d_d    = d_next_c;
          end else begin
            vout_d = 1'b0;
          end
        end
      end
      S_WAIT: begin
        vout_d = 1'b0;
        if (rx_q == CNT_W'(N_VECTORS)) begin
          drain_d = '0;
          state_d = (DRAIN_CYCLES == 0) ? S_DONE : S_DRAIN;
        end
      end
      S_DRAIN: begin
        vout_d = 1'b0;
        if (drain_q == DRAIN_W'(DRAIN_CYCLES - 1)) state_d = S_DONE;
        else                                         drain_d = drain_q + DRAIN_W'(1);
      end
      S_DONE: begin
        vout_d = 1'b0;
      end
      default: begin
        vout_d  = 1'b0;
        state_d = S_IDLE;
      end
    endcase

    // Result counting; a result with nothing outstanding or beyond the total is an error
    if ((state_q != S_IDLE) && VIN) begin
      if ((rx_q == CNT_W'(N_VECTORS)) || (rx_q == tx_q)) err_d = 1'b1;
      if (rx_q != {CNT_W{1'b1}}) rx_d = rx_q + CNT_W'(1);
    end

    // Watchdog: cycles without a result while results are outstanding
    if (VIN || (rx_q == tx_q)) begin
      to_d = '0;
    end else if (((state_q == S_RUN) || (state_q == S_WAIT)) && (rx_q < tx_q)) begin
      if (to_q == TO_W'(TIMEOUT - 1)) begin
        err_d   = 1'b1;
        vout_d  = 1'b0;
        state_d = S_DONE;
      end else begin
        to_d = to_q + TO_W'(1);
      end
    end

    end_d = end_q | (state_d == S_DONE);
  end

  // State registers
  always_ff @(posedge CLK) begin
    if (!RST_n) begin
      state_q <= S_IDLE;
      vout_q  <= 1'b0;
      d_q     <= '0;
      tx_q    <= '0;
      rx_q    <= '0;
      err_q   <= 1'b0;
      end_q   <= 1'b0;
      drain_q <= '0;
      to_q    <= '0;
      bub_q   <= nonzero(~SEED);
      for (int unsigned k = 0; k < NUM_OPERANDS; k++) lfsr_q[k] <= chan_seed(k);
    end else begin
      state_q <= state_d;
      vout_q  <= vout_d;
      d_q     <= d_d;
      tx_q    <= tx_d;
      rx_q    <= rx_d;
      err_q   <= err_d;
      end_q   <= end_d;
      drain_q <= drain_d;
      to_q    <= to_d;
      bub_q   <= bub_d;
      for (int unsigned k = 0; k < NUM_OPERANDS; k++) lfsr_q[k] <= lfsr_d[k];
    end
  end

  assign D       = d_q;
  assign VOUT    = vout_q;
  assign END_SIM = end_q;
  assign ERR     = err_q;
  assign TX_CNT  = tx_q;
  assign RX_CNT  = rx_q;

endmodule

// File: tb/tb_stim_gen_hs.sv
// Bench for stim_gen_hs: two configurations (plain and bubbling) driven with
// random backpressure and a 2-cycle loopback, checked against a reference
// model of the operand sequences and of the counting/termination rules.
module tb_stim_gen_hs;

  localparam int unsigned A_W = 32, A_NOP = 3, A_N = 16, A_DRAIN = 3, A_TO = 16;
  localparam logic [31:0] A_SEED = 32'h1;
  localparam int unsigned B_W = 13, B_NOP = 2, B_N = 64, B_DRAIN = 0, B_TO = 64;
  localparam logic [31:0] B_SEED = 32'hCAFE_0001;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n_a, rst_n_b, en, rdy, vin;

  logic [A_NOP*A_W-1:0] d_a;
  logic                 vout_a, end_a, err_a;
  logic [20:0]          tx_a, rx_a;
  logic [B_NOP*B_W-1:0] d_b;
  logic                 vout_b, end_b, err_b;
  logic [20:0]          tx_b, rx_b;

  stim_gen_hs #(.WIDTH(A_W), .NUM_OPERANDS(A_NOP), .N_VECTORS(A_N), .SEED(A_SEED),
                .BUBBLE_EN(1'b0), .DRAIN_CYCLES(A_DRAIN), .TIMEOUT(A_TO)) u_dut_a (
    .CLK(clk), .RST_n(rst_n_a), .EN(en), .D(d_a), .VOUT(vout_a), .RDY(rdy), .VIN(vin),
    .END_SIM(end_a), .ERR(err_a), .TX_CNT(tx_a), .RX_CNT(rx_a));

  stim_gen_hs #(.WIDTH(B_W), .NUM_OPERANDS(B_NOP), .N_VECTORS(B_N), .SEED(B_SEED),
                .BUBBLE_EN(1'b1), .DRAIN_CYCLES(B_DRAIN), .TIMEOUT(B_TO)) u_dut_b (
    .CLK(clk), .RST_n(rst_n_b), .EN(en), .D(d_b), .VOUT(vout_b), .RDY(rdy), .VIN(vin),
    .END_SIM(end_b), .ERR(err_b), .TX_CNT(tx_b), .RX_CNT(rx_b));

  bit          sel;
  logic [95:0] obs_d;
  logic        obs_vout, obs_end, obs_err;
  logic [20:0] obs_tx, obs_rx;

  always_comb begin
    if (sel) begin
      obs_d = 96'(d_b); obs_vout = vout_b; obs_end = end_b; obs_err = err_b;
      obs_tx = tx_b; obs_rx = rx_b;
    end else begin
      obs_d = d_a; obs_vout = vout_a; obs_end = end_a; obs_err = err_a;
      obs_tx = tx_a; obs_rx = rx_a;
    end
  end

  int n_checks = 0;
  int n_errors = 0;
  int ecount   = 0;

  int          cur_w, cur_nop, cur_n, cur_drain;
  logic [31:0] cur_seed;
  logic [31:0] m_lfsr [8];
  int          m_tx, m_rx;
  int          r_gaps, r_stalls, r_first_xfer, r_first_err, r_first_end, r_last_vin;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (edge %0d)", tag, got, exp, ecount);
    end
  endtask

  // Reference polynomial x^32+x^22+x^2+x+1 in Galois form
  function automatic logic [31:0] ref_next(input logic [31:0] s);
    logic [31:0] r;
    r = {1'b0, s[31:1]};
    if (s[0]) r = r ^ 32'h8020_0003;
    return r;
  endfunction

  task automatic init_model();
    for (int k = 0; k < 8; k++) begin
      m_lfsr[k] = cur_seed ^ (32'(k) * 32'h9E37_79B9);
      if (m_lfsr[k] == 32'h0) m_lfsr[k] = 32'h1;
    end
    m_tx = 0;
    m_rx = 0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    ecount++;
  endtask

  task automatic do_reset(input bit which);
    sel = which;
    rst_n_a = 1'b0; rst_n_b = 1'b0;
    en = 1'b0; rdy = 1'b0; vin = 1'b0;
    tick(); tick();
    if (which) begin
      cur_w = B_W; cur_nop = B_NOP; cur_n = B_N; cur_drain = B_DRAIN; cur_seed = B_SEED;
      rst_n_b = 1'b1;
    end else begin
      cur_w = A_W; cur_nop = A_NOP; cur_n = A_N; cur_drain = A_DRAIN; cur_seed = A_SEED;
      rst_n_a = 1'b1;
    end
    chk("rst_vout", 64'(obs_vout), 64'd0);
    chk("rst_d_lo", obs_d[63:0], 64'd0);
    chk("rst_d_hi", 64'(obs_d[95:64]), 64'd0);
    chk("rst_tx", 64'(obs_tx), 64'd0);
    chk("rst_rx", 64'(obs_rx), 64'd0);
    chk("rst_err", 64'(obs_err), 64'd0);
    chk("rst_end", 64'(obs_end), 64'd0);
    init_model();
  endtask

  // Per-cycle driver/monitor: random RDY, optional 2-cycle loopback of VIN
  task automatic run_loop(input int budget, input int rdy_pct, input bit loop_en,
                          input bit err_free, input int stall_at, input int stop_tx);
    bit [1:0]    pipe;
    bit          xfer, hold_pend;
    logic [95:0] hold_d, sh;
    logic [63:0] mask;
    int          stall_left;
    pipe = 2'b00; hold_pend = 1'b0; hold_d = '0; stall_left = 5;
    mask = (64'd1 << cur_w) - 64'd1;
    r_gaps = 0; r_stalls = 0;
    r_first_xfer = -1; r_first_err = -1; r_first_end = -1; r_last_vin = -1;
    en = 1'b1;
    for (int c = 0; c < budget; c++) begin
      chk("tx_cnt", 64'(obs_tx), 64'(m_tx));
      chk("rx_cnt", 64'(obs_rx), 64'(m_rx));
      if (err_free) chk("err_clear", 64'(obs_err), 64'd0);
      if (obs_err && r_first_err < 0) r_first_err = ecount;
      if (obs_end) begin
        r_first_end = ecount;
        break;
      end
      if (stop_tx != 0 && int'(obs_tx) == stop_tx) break;
      if (hold_pend) begin
        chk("vout_hold", 64'(obs_vout), 64'd1);
        chk("d_hold_lo", obs_d[63:0], hold_d[63:0]);
        chk("d_hold_hi", 64'(obs_d[95:64]), 64'(hold_d[95:64]));
      end
      if (!obs_vout && m_tx >= 1 && m_tx < cur_n) r_gaps++;
      rdy = ($urandom_range(99) < 32'(rdy_pct));
      if (stall_at > 0 && m_tx == stall_at && obs_vout && stall_left > 0) begin
        rdy = 1'b0;
        stall_left--;
        r_stalls++;
      end
      vin = loop_en & pipe[1];
      if (vin) begin
        m_rx++;
        r_last_vin = ecount + 1;
      end
      xfer = obs_vout && rdy;
      if (xfer) begin
        for (int k = 0; k < cur_nop; k++) begin
          sh = obs_d >> (k * cur_w);
          chk($sformatf("d_ch%0d_tx%0d", k, m_tx), 64'(sh[31:0]) & mask, 64'(m_lfsr[k]) & mask);
          m_lfsr[k] = ref_next(m_lfsr[k]);
        end
        m_tx++;
        if (r_first_xfer < 0) r_first_xfer = ecount + 1;
      end
      hold_pend = obs_vout && !rdy;
      hold_d = obs_d;
      tick();
      pipe = {pipe[0], xfer};
    end
    vin = 1'b0;
    rdy = 1'b0;
  endtask

  // Completion of a loopback run: counts, END_SIM latency after last result, stickiness
  task automatic check_done();
    chk("end_reached", 64'(obs_end), 64'd1);
    chk("done_tx", 64'(obs_tx), 64'(cur_n));
    chk("done_rx", 64'(obs_rx), 64'(cur_n));
    chk("done_err", 64'(obs_err), 64'd0);
    chk("end_latency", 64'(r_first_end - r_last_vin), 64'(cur_drain + 1));
    tick(); tick();
    chk("end_sticky", 64'(obs_end), 64'd1);
    chk("done_vout", 64'(obs_vout), 64'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    sel = 1'b0; rst_n_a = 1'b0; rst_n_b = 1'b0;
    en = 1'b0; rdy = 1'b0; vin = 1'b0;
    #1;

    // Full-rate loopback: back-to-back VOUT, seed-first operand sequence
    do_reset(1'b0);
    run_loop(400, 100, 1'b1, 1'b1, 0, 0);
    check_done();
    chk("no_gaps_full_rate", 64'(r_gaps), 64'd0);

    // Random backpressure plus a directed 5-cycle stall
    do_reset(1'b0);
    run_loop(800, 60, 1'b1, 1'b1, 3, 0);
    check_done();
    chk("stall_cycles", 64'(r_stalls), 64'd5);

    // No results ever return: watchdog fires TIMEOUT edges after the first transfer
    do_reset(1'b0);
    run_loop(200, 100, 1'b0, 1'b0, 0, 0);
    chk("to_end", 64'(obs_end), 64'd1);
    chk("to_err", 64'(obs_err), 64'd1);
    chk("to_rx", 64'(obs_rx), 64'd0);
    chk("to_err_edge", 64'(r_first_err - r_first_xfer), 64'(A_TO));
    chk("to_end_edge", 64'(r_first_end - r_first_xfer), 64'(A_TO));

    // Result before any request
    do_reset(1'b0);
    en = 1'b1;
    tick();
    vin = 1'b1;
    tick();
    vin = 1'b0;
    chk("spur_err", 64'(obs_err), 64'd1);
    chk("spur_rx", 64'(obs_rx), 64'd1);
    chk("spur_tx", 64'(obs_tx), 64'd0);

    // Reset mid-run, then a clean restart from the seeds
    do_reset(1'b0);
    run_loop(200, 100, 1'b1, 1'b1, 0, 10);
    chk("pre_rst_tx", 64'(obs_tx), 64'd10);
    rst_n_a = 1'b0;
    tick();
    rst_n_a = 1'b1;
    chk("mid_rst_vout", 64'(obs_vout), 64'd0);
    chk("mid_rst_tx", 64'(obs_tx), 64'd0);
    chk("mid_rst_rx", 64'(obs_rx), 64'd0);
    chk("mid_rst_d", obs_d[63:0], 64'd0);
    init_model();
    run_loop(400, 100, 1'b1, 1'b1, 0, 0);
    check_done();

    // Bubbling configuration, narrow operands, zero drain
    do_reset(1'b1);
    run_loop(3000, 70, 1'b1, 1'b1, 0, 0);
    check_done();
    chk("bubble_seen", 64'(r_gaps > 0), 64'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/stim_gen_hs.md
Name: stim_gen_hs

Overview:
- Parametrised successor to the FPU bench data generator: a synthesizable multi-operand stimulus source for pipelined DUTs such as the FPU top.
- Drives NUM_OPERANDS pseudo-random operands over a valid/ready handshake and issues a programmed number of transactions.
- Optionally inserts random bubbles, counts returned results and raises END_SIM only after every result has returned and a drain period has elapsed.
- Sits between the bench clock generator and the DUT input; its END_SIM feeds the clock generator.

Parameters:
- WIDTH, 32, operand width in bits (1..32).
- NUM_OPERANDS, 3, operand channels driven in parallel (1..8).
- N_VECTORS, 1000, transactions to issue (1..2^20).
- SEED, 32'h1, base LFSR seed.
- BUBBLE_EN, 0, 1 = random idle cycles between transactions.
- DRAIN_CYCLES, 8, cycles from last result to END_SIM (0..255).
- TIMEOUT, 1024, maximum cycles with no VIN while results are outstanding.

Ports:
- CLK  in  1  clock.
- RST_n  in  1  synchronous active-low reset.
- EN  in  1  start/continue issuing; sampled in IDLE and RUN.
- D  out  NUM_OPERANDS*WIDTH  operands; channel k occupies D[k*WIDTH +: WIDTH].
- VOUT  out  1  operands valid.
- RDY  in  1  DUT ready.
- VIN  in  1  DUT result valid; one pulse per result.
- END_SIM  out  1  simulation finished; sticky.
- ERR  out  1  timeout or over-receive error; sticky.
- TX_CNT  out  21  accepted transactions.
- RX_CNT  out  21  results received.

Behaviour:
- Reset: all state is sampled on the CLK rising edge when RST_n=0. State returns to IDLE mid-operation, with no partial drain. Outputs after reset: VOUT=0, D=0, END_SIM=0, ERR=0, TX_CNT=0, RX_CNT=0, drain and timeout counters=0. LFSRs reload their seeds.
- LFSRs:
  - One 32-bit Galois LFSR per channel, polynomial x^32+x^22+x^2+x+1, mask 32'h80200003.
  - Channel k seed = SEED ^ (k*32'h9E3779B9). A seed of 0 is replaced by 32'h1.
  - One extra bubble LFSR, seeded with ~SEED (0 is replaced by 1).
  - D channel k = low WIDTH bits of its LFSR state.
- Handshake:
  - A transfer occurs on any cycle with VOUT=1 and RDY=1.
  - While VOUT=1 and RDY=0, D and VOUT hold stable. Once raised, VOUT is never withdrawn before the transfer.
  - On a transfer, the channel LFSRs step once and TX_CNT increments.
  - The LFSRs never step without a transfer, so the sequence is independent of backpressure.
- FSM:
  - IDLE: VOUT=0. EN=1 -> RUN.
  - RUN:
    - If VOUT=0 and EN=1, decide to issue. With BUBBLE_EN=1, bubble LFSR bits[1:0]==0 means skip this cycle and VOUT stays 0. The bubble LFSR steps every RUN cycle. Otherwise VOUT=1 next cycle.
    - EN=0 only blocks new issues; a pending VOUT still completes.
    - When the transfer that makes TX_CNT=N_VECTORS occurs, VOUT=0 next cycle -> WAIT.
  - WAIT: VOUT=0. RX_CNT==N_VECTORS -> DRAIN.
  - DRAIN: counts DRAIN_CYCLES clocks, then -> DONE. With DRAIN_CYCLES=0, DONE is entered the cycle after RX_CNT reaches N_VECTORS.
  - DONE: END_SIM=1, VOUT=0. Held until reset.
- RX counting:
  - VIN=1 increments RX_CNT in any state except IDLE, saturating at 2^21-1.
  - VIN with RX_CNT already N_VECTORS, or VIN with RX_CNT==TX_CNT (result without request), sets ERR. Counting continues.
  - A transfer and a VIN in the same cycle update both counters independently.
- Timeout:
  - The counter resets on any VIN and whenever RX_CNT==TX_CNT.
  - It increments in RUN and WAIT while RX_CNT<TX_CNT.
  - Reaching TIMEOUT sets ERR and forces DONE immediately, with END_SIM=1 next cycle.
- All outputs are registered.

Test Plan:
- N_VECTORS=4, NUM_OPERANDS=3, SEED=1, RDY=1, EN=1, DUT loopback with 2-cycle latency -> VOUT high 4 consecutive cycles. Channel 0 D sequence = 1, then successive Galois steps of 1. TX_CNT=4, RX_CNT=4. END_SIM asserted exactly DRAIN_CYCLES+1 cycles after the 4th VIN. ERR=0.
- Backpressure: RDY=0 for 5 cycles while VOUT=1 -> D and VOUT constant throughout. The operand sequence equals the RDY=1 case. TX_CNT increments once.
- BUBBLE_EN=1, N_VECTORS=64 -> at least one VOUT=0 cycle inside RUN. Exactly 64 transfers. Operand sequence identical to BUBBLE_EN=0.
- Timeout: TIMEOUT=16, DUT returns no VIN -> ERR=1 and END_SIM=1 at the 16th idle cycle after the first transfer. RX_CNT=0.
- Spurious VIN before any transfer (RUN, TX_CNT=0) -> ERR=1, RX_CNT=1.
- RST_n=0 for one cycle mid-RUN with TX_CNT=10 -> next cycle VOUT=0, TX_CNT=0, state IDLE. After EN=1, channel 0 D restarts at 1.
